bfp16_mul_norm: RTL and testbench



---
 rtl/bfp16_mul_norm_pkg.sv | 36 +++
 rtl/bfp16_round_pack.sv | 47 ++++
 rtl/bfp16_mul_norm.sv | 108 ++++++++++
 tb/tb_bfp16_mul_norm.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfp16_mul_norm_pkg.sv
// Shared bfloat16 constants and pipeline payload types for the
// multiplier normalize/round/pack stage.
package bfp16_mul_norm_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 7;
  localparam int MANT_W  = 16;
  localparam int EXP_S_W = 10;

  localparam int          BF16_BIAS    = 127;
  localparam int          BF16_EXP_MAX = 255;
  localparam logic [14:0] BF16_INF_MAG = 15'h7F80;

  // Sized, signed copies used in the exponent datapath
  localparam logic signed [EXP_S_W-1:0] EXP_S_BIAS   = EXP_S_W'(BF16_BIAS);
  localparam logic signed [EXP_S_W-1:0] EXP_S_MAX    = EXP_S_W'(BF16_EXP_MAX);
  localparam logic [EXP_W-1:0]          EXP_ALL_ONES = EXP_W'(BF16_EXP_MAX);

  // Stage 1 payload: combined sign, unbiased-sum exponent, raw product, specials
  typedef struct packed {
    logic                      sign;
    logic signed [EXP_S_W-1:0] exp_s;
    logic [MANT_W-1:0]         mant;
    logic                      is_zero;
    logic                      is_inf;
  } s1_data_t;

  // Stage 2 payload: packed result plus status flags
  typedef struct packed {
    logic [15:0] result;
    logic        overflow;
    logic        underflow;
    logic        zero;
  } s2_data_t;

endpackage

// File: rtl/bfp16_round_pack.sv
// Round-to-nearest-even and bfloat16 packing with special-case priority.
// Purely combinational so it can be exercised on its own.
module bfp16_round_pack
  import bfp16_mul_norm_pkg::*;
(
  input  logic [FRAC_W-1:0]         frac,
  input  logic                      guard,
  input  logic                      sticky,
  input  logic signed [EXP_S_W-1:0] exp_n,
  input  logic                      sign,
  input  logic                      is_zero,
  input  logic                      is_inf,
  output logic [15:0]               result,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      zero
);

  logic                      round_up;
  logic [FRAC_W:0]           frac_sum;
  logic [FRAC_W-1:0]         frac_r;
  logic signed [EXP_S_W-1:0] exp_r;

  // Round, fold mantissa carry into the exponent, then pick the result by priority
  always_comb begin
    round_up  = guard & (sticky | frac[0]);
    frac_sum  = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
    frac_r    = frac_sum[FRAC_W-1:0];
    exp_r     = exp_n + $signed({{(EXP_S_W-1){1'b0}}, frac_sum[FRAC_W]});
    result    = {sign, exp_r[EXP_W-1:0], frac_r};
    overflow  = 1'b0;
    underflow = 1'b0;
    zero      = 1'b0;
    if (is_zero) begin
      result = {sign, 15'h0};
      zero   = 1'b1;
    end else if (is_inf || (exp_r >= EXP_S_MAX)) begin
      result   = {sign, BF16_INF_MAG};
      overflow = 1'b1;
    end else if (exp_r[EXP_S_W-1] || (exp_r == '0)) begin
      result    = {sign, 15'h0};
      underflow = 1'b1;
      zero      = 1'b1;
    end
  end

endmodule

// File: rtl/bfp16_mul_norm.sv
// Two-stage elastic normalize/round/pack pipeline sitting after the
// bfloat16 mantissa multiplier tree. Stage 1 captures operands, stage 2
// captures the packed result; in_ready is combinational from out_ready.
module bfp16_mul_norm
  import bfp16_mul_norm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [MANT_W-1:0] mant_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       result,
  output logic              overflow,
  output logic              underflow,
  output logic              zero
);

  logic     s1_v;
  logic     s2_v;
  logic     s1_load;
  logic     s2_load;
  s1_data_t s1_d;
  s1_data_t s1_q;
  s2_data_t s2_d;
  s2_data_t s2_q;

  logic [FRAC_W-1:0]         frac;
  logic                      guard;
  logic                      sticky;
  logic signed [EXP_S_W-1:0] exp_n;

  assign s2_load  = !s2_v || out_ready;
  assign in_ready = !s1_v || s2_load;
  assign s1_load  = in_valid && in_ready;

  // Stage 1 input decode: sign, exponent sum less bias, special operand detection
  always_comb begin
    s1_d.sign    = sign_a ^ sign_b;
    s1_d.exp_s   = {2'b00, exp_a} + {2'b00, exp_b} - EXP_S_BIAS;
    s1_d.mant    = mant_prod;
    s1_d.is_zero = (exp_a == '0) || (exp_b == '0);
    s1_d.is_inf  = (exp_a == EXP_ALL_ONES) || (exp_b == EXP_ALL_ONES);
  end

  // Stage 1 register: valid follows the upstream whenever the stage can take data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (s1_load)  s1_q <= s1_d;
    end
  end

  // Normalize the 2.14 product to 1.7 with guard and sticky bits
  always_comb begin
    if (s1_q.mant[15]) begin
      frac   = s1_q.mant[14:8];
      guard  = s1_q.mant[7];
      sticky = |s1_q.mant[6:0];
      exp_n  = s1_q.exp_s + 10'sd1;
    end else begin
      frac   = s1_q.mant[13:7];
      guard  = s1_q.mant[6];
      sticky = |s1_q.mant[5:0];
      exp_n  = s1_q.exp_s;
    end
  end

  bfp16_round_pack u_round_pack (
    .frac      (frac),
    .guard     (guard),
    .sticky    (sticky),
    .exp_n     (exp_n),
    .sign      (s1_q.sign),
    .is_zero   (s1_q.is_zero),
    .is_inf    (s1_q.is_inf),
    .result    (s2_d.result),
    .overflow  (s2_d.overflow),
    .underflow (s2_d.underflow),
    .zero      (s2_d.zero)
  );

  // Stage 2 register: holds the packed result stable until downstream takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2_q <= '0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) s2_q <= s2_d;
    end
  end

  assign out_valid = s2_v;
  assign result    = s2_q.result;
  assign overflow  = s2_q.overflow;
  assign underflow = s2_q.underflow;
  assign zero      = s2_q.zero;

endmodule

// File: tb/tb_bfp16_mul_norm.sv
// Scoreboard bench for bfp16_mul_norm: a driver pushes hand-computed
// expectations as sets are accepted, a negedge monitor pops and compares.
module tb_bfp16_mul_norm;

  typedef struct packed {
    logic        sa;
    logic        sb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [15:0] mp;
    logic [15:0] res;
    logic [2:0]  flags;
  } vec_t;

  typedef struct {
    logic [18:0] value;
    int          stamp;
    bit          timed;
  } sb_entry_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_a;
  logic        sign_b;
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [15:0] mant_prod;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;
  logic        underflow;
  logic        zero;

  logic [18:0] exp_cur;
  int          ready_mode;
  int          timeouts;
  bit          done;
  int          cyc = 0;
  int          errors;
  int          checks;
  vec_t        vecs[$];
  sb_entry_t   sb[$];

  bfp16_mul_norm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .mant_prod (mant_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: held high, random, or held low depending on phase
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic addVec(input logic sa, input logic sb_in, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [15:0] mp, input logic [15:0] res, input logic [2:0] flags);
    vec_t v;
    v.sa = sa; v.sb = sb_in; v.ea = ea; v.eb = eb; v.mp = mp; v.res = res; v.flags = flags;
    vecs.push_back(v);
  endtask

  // Present one set and hold it until the DUT accepts it (bounded)
  task automatic applyStimulus(input vec_t v);
    bit accepted;
    in_valid  = 1'b1;
    sign_a    = v.sa;
    sign_b    = v.sb;
    exp_a     = v.ea;
    exp_b     = v.eb;
    mant_prod = v.mp;
    exp_cur   = {v.res, v.flags};
    accepted  = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      timeouts++;
      $display("[TB] FAIL accept_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      timeouts++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  // Monitor: sampled on the falling edge, owns the scoreboard and the counters
  initial begin
    logic [18:0] held;
    logic [18:0] got;
    logic        hold_valid;
    logic        in_reset;
    logic        exp_ir;
    sb_entry_t   e;
    errors     = 0;
    checks     = 0;
    hold_valid = 1'b0;
    in_reset   = 1'b1;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        hold_valid = 1'b0;
        in_reset   = 1'b1;
      end else begin
        got = {result, overflow, underflow, zero};
        if (in_reset) begin
          checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
          checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
          checkOutput("reset_result_flags", 32'(got), 32'd0);
          in_reset = 1'b0;
        end
        exp_ir = !(sb.size() == 2 && !out_ready);
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ir));
        if (hold_valid) begin
          checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
          checkOutput("stall_result_flags", 32'(got), 32'(held));
        end
        hold_valid = out_valid && !out_ready;
        held       = got;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_output", 32'(out_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("result_flags", 32'(got), 32'(e.value));
            if (e.timed) checkOutput("latency", 32'(cyc - e.stamp), 32'd2);
          end
        end
        if (in_valid && in_ready) begin
          e.value = exp_cur;
          e.stamp = cyc;
          e.timed = (ready_mode == 0);
          sb.push_back(e);
        end
        if (done) begin
          checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
          checkOutput("driver_timeouts", 32'(timeouts), 32'd0);
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $finish;
        end
      end
    end
  end

  // Main sequence: directed, streaming under back-pressure, reset mid-stream
  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    sign_a     = 1'b0;
    sign_b     = 1'b0;
    exp_a      = '0;
    exp_b      = '0;
    mant_prod  = '0;
    exp_cur    = '0;
    ready_mode = 0;
    timeouts   = 0;
    done       = 1'b0;

    //     sa    sb    ea      eb      mant      result    {ovf,unf,zero}
    addVec(1'b0, 1'b0, 8'd127, 8'd127, 16'h4000, 16'h3F80, 3'b000);
    addVec(1'b0, 1'b1, 8'd127, 8'd127, 16'h9000, 16'hC010, 3'b000);
    addVec(1'b0, 1'b0, 8'd127, 8'd127, 16'h40C0, 16'h3F82, 3'b000);
    addVec(1'b0, 1'b0, 8'd127, 8'd127, 16'h4040, 16'h3F80, 3'b000);
    addVec(1'b0, 1'b0, 8'd127, 8'd127, 16'h7FC0, 16'h4000, 3'b000);
    addVec(1'b0, 1'b0, 8'd254, 8'd254, 16'h4000, 16'h7F80, 3'b100);
    addVec(1'b0, 1'b0, 8'd1,   8'd1,   16'h4000, 16'h0000, 3'b011);
    addVec(1'b0, 1'b0, 8'd0,   8'd200, 16'h4000, 16'h0000, 3'b001);
    addVec(1'b1, 1'b0, 8'd255, 8'd100, 16'h4000, 16'hFF80, 3'b100);
    addVec(1'b1, 1'b1, 8'd130, 8'd120, 16'hC000, 16'h3E40, 3'b000);
    addVec(1'b0, 1'b0, 8'd127, 8'd127, 16'h4041, 16'h3F81, 3'b000);
    addVec(1'b0, 1'b0, 8'd127, 8'd127, 16'h8180, 16'h4002, 3'b000);
    addVec(1'b0, 1'b0, 8'd191, 8'd190, 16'h7FC0, 16'h7F80, 3'b100);
    addVec(1'b0, 1'b0, 8'd191, 8'd190, 16'h4000, 16'h7F00, 3'b000);
    addVec(1'b0, 1'b0, 8'd64,  8'd64,  16'h4000, 16'h0080, 3'b000);
    addVec(1'b0, 1'b0, 8'd64,  8'd63,  16'h4000, 16'h0000, 3'b011);
    addVec(1'b0, 1'b0, 8'd64,  8'd63,  16'h8000, 16'h0080, 3'b000);
    addVec(1'b1, 1'b0, 8'd0,   8'd255, 16'h4000, 16'h8000, 3'b001);
    addVec(1'b1, 1'b0, 8'd1,   8'd1,   16'h4000, 16'h8000, 3'b011);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    foreach (vecs[i]) applyStimulus(vecs[i]);
    waitDrain();

    $display("[TB] streaming with random out_ready");
    ready_mode = 1;
    for (int i = 0; i < 20; i++) applyStimulus(vecs[i % vecs.size()]);
    ready_mode = 0;
    waitDrain();

    $display("[TB] reset with both stages full");
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(vecs[1]);
    applyStimulus(vecs[2]);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = 0;
    repeat (6) @(posedge clk);
    #1;
    applyStimulus(vecs[9]);
    waitDrain();

    done = 1'b1;
    repeat (20) @(posedge clk);
    $display("[TB] FAIL monitor_end: got no summary expected summary");
    $fatal(1, "[TB] monitor did not finish");
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got time limit expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
